// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall and operand-forwarding decision.
// Keeps its own in-flight write descriptors for the stages after ID and a
// multiply/divide busy counter, so later stages need not feed decode back.
module hazard_scoreboard #(
   parameter int AW       = 5,
   parameter int TW       = 2,
   parameter int NSTAGE   = 3,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CW       = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [AW-1:0]     id_rs,
   input  logic [AW-1:0]     id_rt,
   input  logic [TW-1:0]     id_rs_tuse,
   input  logic [TW-1:0]     id_rt_tuse,
   input  logic              id_we,
   input  logic [AW-1:0]     id_wa,
   input  logic [TW-1:0]     id_tnew,
   input  logic              id_md_start,
   input  logic              id_md_div,
   input  logic              id_md_read,
   output logic              stall,
   output logic [NSTAGE:0]   fwd_rs_sel,
   output logic [NSTAGE:0]   fwd_rt_sel,
   output logic              md_busy
);

   // Descriptor k describes the instruction currently in stage k (1 = EX).
   logic [NSTAGE:1]              r_v;
   logic [NSTAGE:1][AW-1:0]      r_wa;
   logic [NSTAGE:1][TW-1:0]      r_tnew;
   logic [CW-1:0]                r_md_cnt;

   logic [NSTAGE+1:0]            w_rs_chk;
   logic [NSTAGE+1:0]            w_rt_chk;
   logic                         w_md_stall;
   logic                         w_md_accept;

   // Saturating decrement of a remaining-latency field.
   function automatic logic [TW-1:0] f_dec(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // Operand check against the youngest matching producer.
   // Returns {stall, one-hot select}; select bit 0 is the register file.
   function automatic logic [NSTAGE+1:0] f_check(
      input logic [AW-1:0]             src,
      input logic [TW-1:0]             tuse,
      input logic                      active,
      input logic [NSTAGE:1]           v,
      input logic [NSTAGE:1][AW-1:0]   wa,
      input logic [NSTAGE:1][TW-1:0]   tn
   );
      logic              hit;
      int                kk;
      logic [TW-1:0]     t;
      logic              stl;
      logic [NSTAGE:0]   sel;
      hit = 1'b0;
      kk  = 0;
      t   = '0;
      stl = 1'b0;
      sel = (NSTAGE+1)'(1);
      // Scan oldest to youngest so the youngest producer overrides.
      for (int k = NSTAGE; k >= 1; k--) begin
         if (v[k] && (wa[k] == src)) begin
            hit = 1'b1;
            kk  = k;
            t   = tn[k];
         end
      end
      if (active && hit) begin
         if (t > tuse) begin
            stl = 1'b1;
         end else if (t == '0) begin
            sel = (NSTAGE+1)'(1) << kk;
         end
      end
      return {stl, sel};
   endfunction

   // Hazard decision for both operands and the mult/div unit.
   always_comb begin
      w_rs_chk    = f_check(id_rs, id_rs_tuse, id_valid && (id_rs != '0), r_v, r_wa, r_tnew);
      w_rt_chk    = f_check(id_rt, id_rt_tuse, id_valid && (id_rt != '0), r_v, r_wa, r_tnew);
      w_md_stall  = id_valid & (id_md_read | id_md_start) & md_busy;
      stall       = w_rs_chk[NSTAGE+1] | w_rt_chk[NSTAGE+1] | w_md_stall;
      fwd_rs_sel  = w_rs_chk[NSTAGE:0];
      fwd_rt_sel  = w_rt_chk[NSTAGE:0];
      w_md_accept = id_valid & id_md_start & ~stall;
   end

   assign md_busy = (r_md_cnt != '0);

   // Descriptor pipeline: ID enters stage 1 (bubble on stall), others shift.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v    <= '0;
         r_wa   <= '0;
         r_tnew <= '0;
      end else begin
         r_v[1]    <= id_valid & id_we & (id_wa != '0) & ~stall;
         r_wa[1]   <= id_wa;
         r_tnew[1] <= id_tnew;
         for (int k = 1; k < NSTAGE; k++) begin
            r_v[k+1]    <= r_v[k];
            r_wa[k+1]   <= r_wa[k];
            r_tnew[k+1] <= f_dec(r_tnew[k]);
         end
      end
   end

   // Mult/div busy counter: load on accepted start, otherwise count down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_md_cnt <= '0;
      end else if (w_md_accept) begin
         r_md_cnt <= id_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
      end else if (r_md_cnt != '0) begin
         r_md_cnt <= r_md_cnt - 1'b1;
      end
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed three-stage hazard controller; decides ID-stage stall and ID operand forward source.
- Holds its own in-flight write descriptors, so downstream stages no longer have to feed back RegDst/RegSrc/Tnew decode.
- Tracks a multiply/divide busy counter internally. Sits beside the ID stage and drives the pipeline stall and the ID forwarding muxes.

Parameters:
- AW, 5, register address width; register 0 is hard-wired zero.
- TW, 2, width of the Tuse/Tnew fields.
- NSTAGE, 3, number of tracked stages after ID (1=EX, 2=MEM, 3=WB).
- MULT_CYC, 5, busy cycles after a multiply start.
- DIV_CYC, 10, busy cycles after a divide start.
- CW, 4, busy counter width; must satisfy 2^CW > max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  source register addresses.
- id_rs_tuse, id_rt_tuse  in  TW  cycles after ID until the operand is consumed; an unused operand is driven with address 0.
- id_we  in  1  instruction writes the register file.
- id_wa  in  AW  destination address.
- id_tnew  in  TW  cycles after entering EX until the result exists.
- id_md_start  in  1  mult/div start.
- id_md_div  in  1  1 = divide, 0 = multiply; qualifies id_md_start.
- id_md_read  in  1  mfhi/mflo/mthi/mtlo in ID.
- stall  out  1  freeze PC and IF/ID, bubble into EX (combinational).
- fwd_rs_sel, fwd_rt_sel  out  NSTAGE+1  one-hot forward select (combinational). Bit 0 = register-file value; bit k = stage k write data.
- md_busy  out  1  busy counter nonzero (registered).

Behaviour:
Descriptor pipeline:
- Descriptors e[1..NSTAGE], each {v, wa, tnew}, held in registers and updated every cycle (downstream never stalls).
- e[1] loads {id_valid & id_we & (id_wa!=0) & ~stall, id_wa, id_tnew}. On stall, e[1] loads a bubble (v=0).
- For k ≥ 1, e[k+1] loads e[k] with tnew decremented, saturating at 0. e[NSTAGE] drops off.

Per-operand hazard check (rs and rt independently, src = operand address):
- Operand check is active only when id_valid=1 and src≠0. Otherwise the operand produces no stall and sel = bit 0.
- Match = the smallest k with e[k].v & e[k].wa==src (youngest producer). Older matches are ignored.
- No match: sel = bit 0.
- e[k].tnew > tuse: operand stall; sel = bit 0.
- e[k].tnew == 0: sel = bit k, no stall.
- 0 < e[k].tnew ≤ tuse: no stall, sel = bit 0; the later-stage forwarding resolves the operand.

Multiply/divide:
- Counter md_cnt, CW bits. Accepted start (id_valid & id_md_start & ~stall) loads DIV_CYC if id_md_div, else MULT_CYC.
- Otherwise md_cnt decrements while nonzero.
- md_stall = id_valid & (id_md_read | id_md_start) & md_busy.

Stall and reset:
- stall = rs operand stall | rt operand stall | md_stall.
- Reset clears all e[k].v, wa, tnew and md_cnt. Outputs after reset: stall=0, md_busy=0, both sels = 1.
- Reset during a busy count returns md_busy to 0 immediately (asynchronous).
- All output selects are strictly one-hot.

Test Plan:
- Reset, then id_valid=0 -> stall=0, fwd_rs_sel=fwd_rt_sel=4'b0001, md_busy=0; assert reset mid-sequence -> same values immediately.
- lw $3 (we, wa=3, tnew=2) then beq $3,$0 (rs_tuse=0) -> stall=1 for 2 cycles, then stall=0 with fwd_rs_sel=4'b1000.
- addu $5 (tnew=0) then addu $6,$5,$5 (tuse=1) -> no stall, fwd_rs_sel=fwd_rt_sel=4'b0010. Same with producer tnew=1 -> no stall, sels=4'b0001.
- Descriptor writes: e[1] {wa=4, tnew=1}, e[2] {wa=4, tnew=0}; jr $4 (tuse=0) -> stall=1 (youngest producer wins), next cycle fwd_rs_sel=4'b0100.
- Write to $0 followed by a reader of $0 with tuse=0 -> stall=0, sel=4'b0001.
- mult then mflo -> md_busy=1 for 5 cycles with stall=1 throughout; mflo issues on the 6th. div -> 10 cycles. div, then reset at busy cycle 4 -> md_busy=0, stall=0.
